lc_mem_responder: RTL and testbench

//  Lower-level responder for the cache's lc_* request interface. Acts as the DRAM model/controller below the LLC.

---
 rtl/lc_mem_responder_pkg.sv | 31 +++
 rtl/lc_mem_responder_sync_fifo.sv | 46 ++++
 rtl/lc_mem_responder.sv | 131 +++++++++++++
 tb/tb_lc_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_mem_responder_pkg.sv
// Shared types and helpers for the lc_* memory responder.
package lc_mem_responder_pkg;

  localparam int unsigned B         = 64;
  localparam int unsigned ADDR_BITS = 64;
  localparam int unsigned LINE_BITS = B * 8;
  localparam int unsigned OFS       = $clog2(B);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0] data;
  } mem_req_t;

  // Clear the byte-offset bits so every stored address names a whole line.
  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] a);
    return a & ~ADDR_BITS'(B - 1);
  endfunction

  // Number of address bits that select a backing-store line.
  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/lc_mem_responder_sync_fifo.sv
// Small synchronous FIFO; the caller never pushes when full or pops when empty.
module lc_mem_responder_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              store [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // Payload storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push) store[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_c  = store[rptr];
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/lc_mem_responder.sv
// DRAM model below the LLC: queues line requests, services them in order
// after a fixed latency, returns read lines and absorbs evictions.
module lc_mem_responder
  import lc_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_LINES = 256,
  parameter int unsigned LAT       = 4,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic                 req_we_in,
  input  logic [ADDR_BITS-1:0] req_addr_in,
  input  logic [LINE_BITS-1:0] req_value_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [ADDR_BITS-1:0] resp_addr_out,
  output logic [LINE_BITS-1:0] resp_value_out
);

  localparam int unsigned IDX  = idx_bits(MEM_LINES);
  localparam int unsigned CW   = $clog2(QDEPTH) + 1;
  localparam int unsigned CNTW = $clog2(LAT + 1);

  mem_state_t           state;
  logic [CNTW-1:0]      cnt;
  mem_req_t             svc;
  logic [IDX-1:0]       svc_idx;
  logic [LINE_BITS-1:0] mem [MEM_LINES];

  mem_req_t             push_req;
  mem_req_t             q_head;
  logic                 q_full;
  logic                 q_empty;
  logic [CW-1:0]        q_count;
  logic                 push_c;
  logic                 pop_c;
  logic [CW-1:0]        count_next_c;
  logic                 svc_done_c;

  assign push_c       = req_valid_in & req_ready_out & ~q_full;
  assign pop_c        = (state == IDLE) & ~q_empty;
  assign count_next_c = q_count + CW'(push_c) - CW'(pop_c);
  assign svc_idx      = svc.addr[OFS +: IDX];
  assign svc_done_c   = (state == WAIT) && (cnt == '0);

  // Queue entries carry line-aligned addresses only.
  always_comb begin
    push_req      = '0;
    push_req.we   = req_we_in;
    push_req.addr = line_addr(req_addr_in);
    push_req.data = req_value_in;
  end

  lc_mem_responder_sync_fifo #(
    .T     (mem_req_t),
    .DEPTH (QDEPTH)
  ) u_req_q (
    .clk     (clk_in),
    .rst_n   (rst_N_in),
    .push    (push_c),
    .din     (push_req),
    .pop     (pop_c),
    .head_c  (q_head),
    .full_c  (q_full),
    .empty_c (q_empty),
    .count   (q_count)
  );

  // Ready reflects the occupancy left behind by this edge's push and pop.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      req_ready_out <= 1'b0;
    end else begin
      req_ready_out <= (count_next_c < CW'(QDEPTH));
    end
  end

  // Backing store: zeroed on reset, written when an eviction finishes its latency.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int unsigned i = 0; i < MEM_LINES; i++) mem[i] <= '0;
    end else if (svc_done_c && svc.we) begin
      mem[svc_idx] <= svc.data;
    end
  end

  // Service FSM with latency counter and registered response channel.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state          <= IDLE;
      cnt            <= '0;
      svc            <= '0;
      resp_valid_out <= 1'b0;
      resp_addr_out  <= '0;
      resp_value_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            svc   <= q_head;
            cnt   <= CNTW'(LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else if (svc.we) begin
            state <= IDLE;
          end else begin
            resp_value_out <= mem[svc_idx];
            resp_addr_out  <= svc.addr;
            resp_valid_out <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_in) begin
            resp_valid_out <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_mem_responder.sv
// Bench for lc_mem_responder: constant vector table, hand sequences for
// latency/backpressure/reset, and random traffic against a line-level model.
module tb_lc_mem_responder;

  typedef logic [511:0] line_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  byt;
    logic [63:0] exp_addr;
    logic [7:0]  exp_byt;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    line_t       value;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_out;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  line_t       req_value = '0;
  logic        resp_valid_out;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_addr_out;
  line_t       resp_value_out;

  int n_vec = 0;
  int n_bad = 0;

  logic bp_mode = 1'b0;
  logic bp_fixed = 1'b0;

  line_t mdl [256];
  resp_t exp_q [$];
  vec_t  tbl [10];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] prev_addr = '0;
  line_t       prev_value = '0;

  lc_mem_responder dut (
    .clk_in         (clk),
    .rst_N_in       (rst_n),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready_out),
    .req_we_in      (req_we),
    .req_addr_in    (req_addr),
    .req_value_in   (req_value),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready),
    .resp_addr_out  (resp_addr_out),
    .resp_value_out (resp_value_out)
  );

  always #5 clk = ~clk;

  // Line index and aligned address from plain arithmetic on the byte address.
  function automatic int line_idx(input logic [63:0] a);
    return int'((a / 64) % 256);
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] a);
    return a - (a % 64);
  endfunction

  task automatic chk(input string nm, input line_t act, input line_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    exp_q.delete();
  endtask

  // Offer one request until accepted, then record its effect in the model.
  task automatic send(input logic we, input logic [63:0] a, input line_t d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_value = d;
    while (!req_ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_out) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_accept_timeout: addr %h never accepted", a);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (we) begin
        mdl[line_idx(a)] = d;
      end else begin
        resp_t r;
        r.addr  = line_base(a);
        r.value = mdl[line_idx(a)];
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  // Response acceptance is driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    resp_ready = bp_mode ? 1'($urandom_range(0, 1)) : bp_fixed;
  end

  // Scoreboard: hold-while-stalled and in-order content of every accepted response.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        n_vec++;
        if (!(resp_valid_out && resp_addr_out == prev_addr && resp_value_out == prev_value)) begin
          n_bad++;
          $display("FAIL resp_hold: valid %b addr %h, expected valid 1 addr %h held",
                   resp_valid_out, resp_addr_out, prev_addr);
        end
      end
      if (resp_valid_out && resp_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: addr %h with no outstanding read", resp_addr_out);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          if (resp_addr_out !== e.addr || resp_value_out !== e.value) begin
            n_bad++;
            $display("FAIL resp_data: addr %h value %h expected addr %h value %h",
                     resp_addr_out, resp_value_out, e.addr, e.value);
          end
        end
      end
      prev_valid = resp_valid_out;
      prev_ready = resp_ready;
      prev_addr  = resp_addr_out;
      prev_value = resp_value_out;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 64'h2040,               8'hA5, 64'h0,                  8'h00};
    tbl[1] = '{1'b0, 64'h2047,               8'h00, 64'h2040,               8'hA5};
    tbl[2] = '{1'b1, 64'h0,                  8'h3C, 64'h0,                  8'h00};
    tbl[3] = '{1'b0, 64'h4000,               8'h00, 64'h4000,               8'h3C};
    tbl[4] = '{1'b1, 64'h1FFF_FFFF_FFFF_FFC0, 8'h5A, 64'h0,                  8'h00};
    tbl[5] = '{1'b0, 64'h3FC5,               8'h00, 64'h3FC0,               8'h5A};
    tbl[6] = '{1'b1, 64'h2040,               8'h11, 64'h0,                  8'h00};
    tbl[7] = '{1'b0, 64'h2040,               8'h00, 64'h2040,               8'h11};
    tbl[8] = '{1'b0, 64'h80,                 8'h00, 64'h80,                 8'h00};
    tbl[9] = '{1'b0, 64'hFFFF_FFFF_FFFF_C03F, 8'h00, 64'hFFFF_FFFF_FFFF_C000, 8'h3C};

    model_clear();

    // Reset held three cycles: all outputs low.
    repeat (3) @(negedge clk);
    chk("rst_ready", line_t'(req_ready_out), '0);
    chk("rst_valid", line_t'(resp_valid_out), '0);
    chk("rst_addr", line_t'(resp_addr_out), '0);
    chk("rst_value", resp_value_out, '0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_release_ready", line_t'(req_ready_out), line_t'(1));

    // Cold read latency: valid first seen after edge LAT+1.
    send(1'b0, 64'h1000, '0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_edge%0d", k), line_t'(resp_valid_out), line_t'(k == 5));
    end
    chk("lat_addr", line_t'(resp_addr_out), line_t'(64'h1000));
    chk("lat_value", resp_value_out, '0);
    bp_fixed = 1'b1;
    drain();

    // Constant vector table.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = tbl[i].byt;
      send(tbl[i].we, tbl[i].addr, {64{b}});
      if (!tbl[i].we) begin
        int n;
        logic [7:0] eb;
        n = 0;
        eb = tbl[i].exp_byt;
        @(negedge clk);
        while (!resp_valid_out && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("tbl%0d_valid", i), line_t'(resp_valid_out), line_t'(1));
        chk($sformatf("tbl%0d_addr", i), line_t'(resp_addr_out), line_t'(tbl[i].exp_addr));
        chk($sformatf("tbl%0d_value", i), resp_value_out, {64{eb}});
      end
    end
    drain();

    // Backpressure: stall responses until the queue fills and ready drops.
    bp_fixed = 1'b0;
    repeat (2) @(negedge clk);
    send(1'b0, 64'h2040, '0);
    send(1'b0, 64'h0,    '0);
    send(1'b0, 64'h3FC0, '0);
    send(1'b0, 64'h80,   '0);
    send(1'b0, 64'h1000, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("full_ready%0d", k), line_t'(req_ready_out), '0);
    end
    bp_fixed = 1'b1;
    send(1'b0, 64'h4000, '0);
    drain();

    // Reset during a read's wait phase discards it and clears memory.
    send(1'b1, 64'h5000, {64{8'h77}});
    drain();
    send(1'b0, 64'h5000, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_valid", line_t'(resp_valid_out), '0);
    chk("midrst_ready", line_t'(req_ready_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_quiet%0d", k), line_t'(resp_valid_out), '0);
    end
    send(1'b0, 64'h5000, '0);
    drain();

    // Random traffic with random response backpressure and aliased lines.
    bp_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [63:0] a;
      line_t       d;
      we = 1'($urandom_range(0, 1));
      a  = (64'($urandom_range(0, 3)) << 14) | (64'($urandom_range(0, 7)) << 6)
         | 64'($urandom_range(0, 63));
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
      send(we, a, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bp_mode = 1'b0;
    bp_fixed = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
